// File: rtl/worm_pkg.sv
// Shared types and constants for the worm display encoder and its helpers.
package worm_pkg;

  localparam int WORM_W = 6;
  localparam int POS_W  = 3;

  localparam logic [POS_W-1:0] LAST_POS = 3'd5;

  // Tracking state: SYNC has no reference, TRACK holds the previous position.
  typedef enum logic {
    SYNC  = 1'b0,
    TRACK = 1'b1
  } worm_state_e;

  // One-hot display patterns. Position 0 is the leftmost (MSB) segment.
  localparam logic [WORM_W-1:0] POS0_OH = 6'b100000;
  localparam logic [WORM_W-1:0] POS1_OH = 6'b010000;
  localparam logic [WORM_W-1:0] POS2_OH = 6'b001000;
  localparam logic [WORM_W-1:0] POS3_OH = 6'b000100;
  localparam logic [WORM_W-1:0] POS4_OH = 6'b000010;
  localparam logic [WORM_W-1:0] POS5_OH = 6'b000001;

  // Binary position to display pattern, the inverse of worm_onehot2bin.
  function automatic logic [WORM_W-1:0] pos2onehot(input logic [POS_W-1:0] p);
    return POS0_OH >> p;
  endfunction

endpackage

// File: rtl/worm_onehot2bin.sv
// Combinational one-hot to binary position converter with a legality flag.
// Bit WORM_W-1 maps to position 0. pos is only meaningful when legal=1.
module worm_onehot2bin
  import worm_pkg::*;
(
  input  logic [WORM_W-1:0] onehot,
  output logic [POS_W-1:0]  pos,
  output logic              legal
);

  // Exactly one bit set is legal; the position is the index counted from the MSB.
  always_comb begin
    pos = '0;
    for (int i = 0; i < WORM_W; i++) begin
      if (onehot[WORM_W-1-i]) begin
        pos = POS_W'(i);
      end
    end
    legal = (onehot != '0) && ((onehot & (onehot - WORM_W'(1))) == '0);
  end

endmodule

// File: rtl/worm_encoder.sv
// Worm display encoder: recovers branch flag and 3-bit displacement from
// successive one-hot worm samples, flags illegal patterns and transitions.
// Optional statistics counters are built when WORM_ENCODER_STATS_EN is defined;
// otherwise both counter outputs read 0 and clr_stats is ignored.
module worm_encoder
  import worm_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clkin,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [WORM_W-1:0] display_worm,
  input  logic              clr_stats,
  output logic              out_valid,
  output logic [POS_W-1:0]  pos,
  output logic              branch,
  output logic [POS_W-1:0]  imm_rec,
  output logic              imm_ambig,
  output logic              err,
  output logic              locked,
  output logic [CNT_W-1:0]  branch_count,
  output logic [CNT_W-1:0]  err_count
);

  worm_state_e        state_q, state_d;
  logic [POS_W-1:0]   ref_q, ref_d;
  logic               out_valid_q, out_valid_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic               branch_q, branch_d;
  logic [POS_W-1:0]   imm_q, imm_d;
  logic               ambig_q, ambig_d;
  logic               err_q, err_d;
  logic               locked_q, locked_d;

  logic [POS_W-1:0]   n_pos;
  logic               n_legal;
  logic               fault;

  worm_onehot2bin u_onehot2bin (
    .onehot (display_worm),
    .pos    (n_pos),
    .legal  (n_legal)
  );

  // Next-state decode: compare the new sample with the held reference.
  always_comb begin
    state_d     = state_q;
    ref_d       = ref_q;
    out_valid_d = 1'b0;
    err_d       = 1'b0;
    pos_d       = pos_q;
    branch_d    = branch_q;
    imm_d       = imm_q;
    ambig_d     = ambig_q;
    locked_d    = locked_q;
    fault       = 1'b0;

    if (in_valid) begin
      if (!n_legal) begin
        fault = 1'b1;
      end else begin
        case (state_q)
          SYNC: begin
            ref_d    = n_pos;
            locked_d = 1'b1;
            state_d  = TRACK;
          end
          TRACK: begin
            if (ref_q == LAST_POS) begin
              // From the last position only the sequential return to 0 is possible.
              if (n_pos == '0) begin
                out_valid_d = 1'b1;
                pos_d       = n_pos;
                imm_d       = '0;
                branch_d    = 1'b0;
                ambig_d     = 1'b0;
                ref_d       = n_pos;
              end else begin
                fault = 1'b1;
              end
            end else if (n_pos == LAST_POS) begin
              // Landing on the last position hides decoder counts 5..7; report the lowest.
              out_valid_d = 1'b1;
              pos_d       = n_pos;
              imm_d       = 3'd4 - ref_q;
              branch_d    = ((3'd4 - ref_q) != '0);
              ambig_d     = 1'b1;
              ref_d       = n_pos;
            end else begin
              // Mod-8 step minus the sequential increment; wrap-arounds are legal.
              out_valid_d = 1'b1;
              pos_d       = n_pos;
              imm_d       = n_pos - ref_q - 3'd1;
              branch_d    = ((n_pos - ref_q - 3'd1) != '0);
              ambig_d     = 1'b0;
              ref_d       = n_pos;
            end
          end
          default: begin
            state_d = SYNC;
          end
        endcase
      end

      if (fault) begin
        // Any error drops the reference; decode fields are zeroed alongside the err pulse.
        out_valid_d = 1'b1;
        err_d       = 1'b1;
        pos_d       = '0;
        branch_d    = 1'b0;
        imm_d       = '0;
        ambig_d     = 1'b0;
        locked_d    = 1'b0;
        ref_d       = '0;
        state_d     = SYNC;
      end
    end
  end

  // Tracking state and registered decode outputs.
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= SYNC;
      ref_q       <= '0;
      out_valid_q <= 1'b0;
      pos_q       <= '0;
      branch_q    <= 1'b0;
      imm_q       <= '0;
      ambig_q     <= 1'b0;
      err_q       <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ref_q       <= ref_d;
      out_valid_q <= out_valid_d;
      pos_q       <= pos_d;
      branch_q    <= branch_d;
      imm_q       <= imm_d;
      ambig_q     <= ambig_d;
      err_q       <= err_d;
      locked_q    <= locked_d;
    end
  end

  assign out_valid = out_valid_q;
  assign pos       = pos_q;
  assign branch    = branch_q;
  assign imm_rec   = imm_q;
  assign imm_ambig = ambig_q;
  assign err       = err_q;
  assign locked    = locked_q;

`ifdef WORM_ENCODER_STATS_EN
  logic [CNT_W-1:0] branch_count_q, branch_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  // Saturating counters; a clear in the same cycle as an increment wins.
  always_comb begin
    branch_count_d = branch_count_q;
    err_count_d    = err_count_q;
    if (clr_stats) begin
      branch_count_d = '0;
      err_count_d    = '0;
    end else begin
      if (out_valid_d && branch_d && !(&branch_count_q)) begin
        branch_count_d = branch_count_q + CNT_W'(1);
      end
      if (err_d && !(&err_count_q)) begin
        err_count_d = err_count_q + CNT_W'(1);
      end
    end
  end

  // Counter registers, cleared by reset like the rest of the state.
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      branch_count_q <= '0;
      err_count_q    <= '0;
    end else begin
      branch_count_q <= branch_count_d;
      err_count_q    <= err_count_d;
    end
  end

  assign branch_count = branch_count_q;
  assign err_count    = err_count_q;
`else
  logic unused_clr_stats;

  assign unused_clr_stats = clr_stats;
  assign branch_count     = '0;
  assign err_count        = '0;
`endif

endmodule

// File: tb/tb_worm_encoder.sv
// Directed testbench for worm_encoder with hand-computed expectations.
// Counter expectations collapse to 0 when WORM_ENCODER_STATS_EN is undefined.
module tb_worm_encoder;

  localparam int CNT_W = 2;
`ifdef WORM_ENCODER_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic             clkin;
  logic             reset_n;
  logic             in_valid;
  logic [5:0]       display_worm;
  logic             clr_stats;
  logic             out_valid;
  logic [2:0]       pos;
  logic             branch;
  logic [2:0]       imm_rec;
  logic             imm_ambig;
  logic             err;
  logic             locked;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] err_count;

  int n_checks = 0;
  int n_fail   = 0;

  worm_encoder #(.CNT_W(CNT_W)) dut (
    .clkin        (clkin),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .display_worm (display_worm),
    .clr_stats    (clr_stats),
    .out_valid    (out_valid),
    .pos          (pos),
    .branch       (branch),
    .imm_rec      (imm_rec),
    .imm_ambig    (imm_ambig),
    .err          (err),
    .locked       (locked),
    .branch_count (branch_count),
    .err_count    (err_count)
  );

  initial begin
    clkin = 1'b0;
    forever #5 clkin = ~clkin;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_cnt(input int v);
    return STATS_ON ? v : 0;
  endfunction

  function automatic logic [5:0] oh(input int p);
    logic [5:0] base;
    base = 6'b100000;
    return base >> p;
  endfunction

  // Present one sample on the next edge and look at the result 1 time unit later.
  task automatic drive(input logic [5:0] w);
    in_valid     = 1'b1;
    display_worm = w;
    @(posedge clkin);
    #1;
    in_valid     = 1'b0;
    display_worm = 6'b000000;
    $display("t=%0t in=%b ov=%b pos=%0d br=%b imm=%0d amb=%b err=%b lk=%b bc=%0d ec=%0d",
             $time, w, out_valid, pos, branch, imm_rec, imm_ambig, err, locked,
             branch_count, err_count);
  endtask

  task automatic expect_out(input string tag, input bit ov, input int p, input bit br,
                            input int imm, input bit amb, input bit er, input bit lk);
    check({tag, ".out_valid"}, out_valid, ov);
    check({tag, ".err"}, err, er);
    check({tag, ".locked"}, locked, lk);
    if (ov) begin
      check({tag, ".pos"}, pos, p);
      check({tag, ".branch"}, branch, br);
      check({tag, ".imm_rec"}, imm_rec, imm);
      check({tag, ".imm_ambig"}, imm_ambig, amb);
    end
  endtask

  task automatic expect_all_zero(input string tag);
    check({tag, ".out_valid"}, out_valid, 0);
    check({tag, ".pos"}, pos, 0);
    check({tag, ".branch"}, branch, 0);
    check({tag, ".imm_rec"}, imm_rec, 0);
    check({tag, ".imm_ambig"}, imm_ambig, 0);
    check({tag, ".err"}, err, 0);
    check({tag, ".locked"}, locked, 0);
    check({tag, ".branch_count"}, branch_count, 0);
    check({tag, ".err_count"}, err_count, 0);
  endtask

  // Assert reset between clock edges and check that outputs clear without a clock.
  task automatic do_reset(input string tag);
    #2;
    reset_n = 1'b0;
    #1;
    expect_all_zero(tag);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n      = 1'b0;
    in_valid     = 1'b0;
    display_worm = 6'b000000;
    clr_stats    = 1'b0;
    #2;
    expect_all_zero("reset");
    #10;
    reset_n = 1'b1;
    @(negedge clkin);

    // Sequential walk 0..5,0: only sequential steps, 4->5 is ambiguous with count 0.
    drive(oh(0));
    expect_out("walk_lock", 0, 0, 0, 0, 0, 0, 1);
    for (int n = 1; n <= 6; n++) begin
      drive(oh(n % 6));
      expect_out($sformatf("walk_%0d", n % 6), 1, n % 6, 0, 0, (n == 5), 0, 1);
    end
    check("walk.err_count", err_count, exp_cnt(0));
    check("walk.branch_count", branch_count, exp_cnt(0));

    // Idle cycle changes nothing.
    @(posedge clkin);
    #1;
    check("idle.out_valid", out_valid, 0);
    check("idle.locked", locked, 1);

    // Branch then wrap.
    do_reset("rst_branch");
    drive(oh(0));
    expect_out("br_lock", 0, 0, 0, 0, 0, 0, 1);
    drive(oh(3));
    expect_out("br_0to3", 1, 3, 1, 2, 0, 0, 1);
    drive(oh(2));
    expect_out("br_3to2", 1, 2, 1, 6, 0, 0, 1);
    check("br.branch_count", branch_count, exp_cnt(2));

    // Ambiguous landing on the last position, then the clean return.
    do_reset("rst_ambig");
    drive(oh(1));
    drive(oh(5));
    expect_out("amb_1to5", 1, 5, 1, 3, 1, 0, 1);
    drive(oh(0));
    expect_out("amb_5to0", 1, 0, 0, 0, 0, 0, 1);
    check("amb.branch_count", branch_count, exp_cnt(1));

    // Errors: illegal transition, then re-lock, then non-one-hot patterns.
    do_reset("rst_err");
    drive(oh(5));
    drive(oh(2));
    expect_out("err_5to2", 1, 0, 0, 0, 0, 1, 0);
    check("err1.err_count", err_count, exp_cnt(1));
    drive(oh(1));
    expect_out("err_relock", 0, 0, 0, 0, 0, 0, 1);
    drive(6'b000110);
    expect_out("err_two_hot", 1, 0, 0, 0, 0, 1, 0);
    check("err2.err_count", err_count, exp_cnt(2));
    drive(6'b000000);
    expect_out("err_zero", 1, 0, 0, 0, 0, 1, 0);
    check("err3.err_count", err_count, exp_cnt(3));
    drive(6'b110000);
    drive(6'b000011);
    expect_out("err_five", 1, 0, 0, 0, 0, 1, 0);
    check("err_sat.err_count", err_count, exp_cnt(3));
    clr_stats = 1'b1;
    drive(6'b111111);
    clr_stats = 1'b0;
    expect_out("err_clr", 1, 0, 0, 0, 0, 1, 0);
    check("clr.err_count", err_count, 0);

    // Same position twice in TRACK is a full-circle branch of 7.
    drive(oh(2));
    drive(oh(2));
    expect_out("same_pos", 1, 2, 1, 7, 0, 0, 1);
    check("same.branch_count", branch_count, exp_cnt(1));

    // Reset mid-stream, then re-sync across an idle cycle.
    do_reset("rst_mid");
    drive(oh(4));
    expect_out("mid_lock", 0, 0, 0, 0, 0, 0, 1);
    @(posedge clkin);
    #1;
    drive(oh(1));
    expect_out("mid_4to1", 1, 1, 1, 4, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/worm_encoder.md
# worm_encoder

Recovers control-flow information from the 6-bit one-hot worm display stream produced by the worm display decoder. Each sample is compared with the previous one, and the block reconstructs the branch flag and the 3-bit branch displacement that produced the step. It also flags illegal patterns and transitions. It sits on the observation/debug side of the CPU display path, in the `clkin` domain, and feeds the self-check and statistics logic.

## Interface
- `CNT_W`, default 8: width of the statistics counters.
- `clkin` in 1: system clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: `display_worm` is sampled on this cycle.
- `display_worm` in 6: one-hot worm pattern; `100000` is position 0, `000001` is position 5.
- `clr_stats` in 1: synchronous clear of the statistics counters.
- `out_valid` out 1: one-cycle pulse; the decode fields are valid.
- `pos` out 3: binary position of the current sample, 0..5.
- `branch` out 1: the recovered displacement is nonzero.
- `imm_rec` out 3: recovered displacement, matching `imm_extended[2:0]` at the decoder.
- `imm_ambig` out 1: the displacement is not unique; `imm_rec` holds the lowest candidate.
- `err` out 1: protocol error pulse, qualified by `out_valid`.
- `locked` out 1: a reference position is held.
- `branch_count` out `CNT_W`: saturating count of decodes with `branch`=1.
- `err_count` out `CNT_W`: saturating count of `err` pulses.

## Operation
- **States:** SYNC (no reference) and TRACK (reference `p` held). Reset enters SYNC.
- **Pattern check:** a sample with no bit set or with more than one bit set is non-one-hot.
  - In any state it gives `out_valid`=1, `err`=1, all other decode fields 0.
  - The next state is SYNC and the reference is discarded.
- **SYNC:** a legal sample stores `p`, sets `locked` and moves to TRACK. There is no `out_valid` pulse.
- **TRACK:** a legal new position `n` is decoded against `p` with mod-8 arithmetic.
  - `p`=5, `n`=0: `imm_rec`=0, `branch`=0, no error.
  - `p`=5, `n`≠0: `err`=1, next state SYNC.
  - `p`<5, `n`<5: `imm_rec` = (`n`−`p`−1) mod 8. `branch` = (`imm_rec`≠0). `imm_ambig`=0.
    - Wrap cases are legal, e.g. `p`=3, `n`=2 gives `imm_rec`=6.
  - `p`<5, `n`=5: the decoder count may be 5, 6 or 7.
    - `imm_rec` = (4−`p`) mod 8. `branch` = (`imm_rec`≠0). `imm_ambig`=1.
  - After a legal transition `n` becomes `p`, and `pos` = `n`.
- **Limitation:** a taken branch with displacement 0 cannot be distinguished from a sequential step. It is reported as `branch`=0.
- **Idle cycles:** cycles with `in_valid`=0 change nothing.

## Timing
- All outputs are registered.
- Decode latency is 1 cycle: a sample taken at edge k produces `out_valid` during cycle k+1.
- Back-to-back `in_valid` is supported; the block never stalls and has no backpressure.
- Reset values: all outputs 0, state SYNC.
- `reset_n` asserted mid-stream clears state, reference and counters immediately, with no clock needed.
- `locked` falls in the same cycle that `err` is presented.
- Counters saturate at all-ones.
- If `clr_stats` and an increment occur in the same cycle, `clr_stats` wins and the count becomes 0.

## Configuration
- Macro: `WORM_ENCODER_STATS_EN`.
- **Defined:** `branch_count` and `err_count` are implemented as above.
- **Undefined:** both counter outputs are tied to 0 and `clr_stats` is ignored. All other behaviour is unchanged.

## Structure
- Package `worm_pkg` holds:
  - `WORM_W`=6, `POS_W`=3, `LAST_POS`=5;
  - the state enum {SYNC, TRACK};
  - the one-hot position constants.
- Sub-module `worm_onehot2bin`: combinational one-hot to binary conversion with a legal flag. It is also reusable by the display checker.

## Test plan
- **Sequential walk:** reset, then `in_valid` samples 0,1,2,3,4,5,0. After the first sample `locked`=1. Expect six `out_valid` pulses, all with `branch`=0, `imm_rec`=0, and `err_count`=0.
- **Branch and wrap:**
  - Samples 0 then 3: expect `branch`=1, `imm_rec`=2.
  - Then sample 2: expect `imm_rec`=6 (wrap case), `branch_count`=2.
- **Ambiguous landing:** samples 1 then 5. Expect `imm_rec`=3, `branch`=1, `imm_ambig`=1. Then sample 0: expect a clean decode.
- **Errors:**
  - Samples 5 then 2: expect `err`=1, `locked`=0, `err_count`=1. The next sample gives no pulse and re-locks.
  - Sample `000110`: expect `err`=1.
  - Sample `000000`: expect `err`=1.
- **Stats boundary:** with `CNT_W`=2, force five errors and expect `err_count`=3. Assert `clr_stats` in the same cycle as an error and expect 0.
- **Reset mid-stream:** pull `reset_n` low between edges. Expect all outputs 0 asynchronously, then re-sync on the first legal sample after release.
